// File: rtl/oam_dma.sv
// Sprite DMA engine: a write of page P to $4014 halts the CPU and copies
// $PP00-$PPFF into OAM through 256 read/write pairs to OAMDATA.
module oam_dma #(
  parameter logic [15:0] OAM_DATA_ADDRESS = 16'h2004
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ce,
  input  logic        i_reg_wr,
  input  logic [7:0]  i_reg_data,
  input  logic [7:0]  i_data,
  output logic [15:0] o_address,
  output logic [7:0]  o_data,
  output logic        o_rw_n,
  output logic        o_bus_request,
  output logic        o_rdy,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

  state_t      state, state_next;
  logic        r_parity;
  logic [7:0]  r_index, index_next;
  logic [7:0]  r_page, page_next;
  logic [7:0]  r_buffer, buffer_next;

  logic        rdy_next, busy_next, bus_request_next, rw_n_next, done_next;
  logic [15:0] address_next;
  logic [7:0]  data_next;

  // State, datapath and registered outputs; everything advances on a ce cycle only.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      r_parity      <= 1'b0;
      r_index       <= 8'h00;
      r_page        <= 8'h00;
      r_buffer      <= 8'h00;
      o_address     <= 16'h0000;
      o_data        <= 8'h00;
      o_rw_n        <= 1'b1;
      o_bus_request <= 1'b0;
      o_rdy         <= 1'b1;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else if (i_ce) begin
      state         <= state_next;
      r_parity      <= ~r_parity;
      r_index       <= index_next;
      r_page        <= page_next;
      r_buffer      <= buffer_next;
      o_address     <= address_next;
      o_data        <= data_next;
      o_rw_n        <= rw_n_next;
      o_bus_request <= bus_request_next;
      o_rdy         <= rdy_next;
      o_busy        <= busy_next;
      o_done        <= done_next;
    end else begin
      state <= state;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_next  = state;
    index_next  = r_index;
    page_next   = r_page;
    buffer_next = r_buffer;
    case (state)
      IDLE: begin
        if (i_reg_wr) begin
          page_next  = i_reg_data;
          index_next = 8'h00;
          state_next = HALT;
        end else begin
          state_next = IDLE;
        end
      end
      // Parity 1 now means the following cycle is a get cycle, ready for READ.
      HALT:  state_next = r_parity ? READ : ALIGN;
      ALIGN: state_next = READ;
      READ: begin
        buffer_next = i_data;
        state_next  = WRITE;
      end
      WRITE: begin
        if (r_index == 8'hFF) begin
          state_next = IDLE;
        end else begin
          index_next = r_index + 8'd1;
          state_next = READ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output values for the state being entered, so the registered outputs are Moore.
  always_comb begin
    rdy_next         = 1'b1;
    busy_next        = 1'b0;
    bus_request_next = 1'b0;
    rw_n_next        = 1'b1;
    address_next     = 16'h0000;
    data_next        = 8'h00;
    done_next        = (state == WRITE) && (r_index == 8'hFF);
    case (state_next)
      IDLE: begin
        rdy_next = 1'b1;
      end
      HALT, ALIGN: begin
        rdy_next  = 1'b0;
        busy_next = 1'b1;
      end
      READ: begin
        rdy_next         = 1'b0;
        busy_next        = 1'b1;
        bus_request_next = 1'b1;
        address_next     = {page_next, index_next};
      end
      WRITE: begin
        rdy_next         = 1'b0;
        busy_next        = 1'b1;
        bus_request_next = 1'b1;
        rw_n_next        = 1'b0;
        address_next     = OAM_DATA_ADDRESS;
        data_next        = buffer_next;
      end
      default: rdy_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: stimulus queues the expected bus cycles,
// a monitor checks each ce cycle's outputs against the queue.
module tb_oam_dma;

  typedef struct {
    logic [15:0] addr;
    logic        rw_n;
    logic [7:0]  data;
  } bus_t;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_ce = 1'b1;
  logic        i_reg_wr = 1'b0;
  logic [7:0]  i_reg_data = 8'h00;
  logic [7:0]  i_data;
  logic [15:0] o_address;
  logic [7:0]  o_data;
  logic        o_rw_n, o_bus_request, o_rdy, o_busy, o_done;

  bus_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   rdy_low_cnt = 0;
  int   done_cnt = 0;
  int   exp_low = 0;
  int   low_base = 0;
  int   done_base = 0;
  logic cyc_par = 1'b0;
  logic ce_rand = 1'b0;

  // CPU memory: for page $03 this gives mem[$0300+n] = n ^ $A5.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ 8'hA5 ^ a[15:8] ^ 8'h03;
  endfunction

  assign i_data = mem_byte(o_address);

  oam_dma dut (
    .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_reg_wr(i_reg_wr),
    .i_reg_data(i_reg_data), .i_data(i_data), .o_address(o_address),
    .o_data(o_data), .o_rw_n(o_rw_n), .o_bus_request(o_bus_request),
    .o_rdy(o_rdy), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) i_ce = ce_rand ? ($urandom_range(0, 2) != 0) : 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one evaluation per clock edge, sampled 1 time unit after it.
  initial begin : monitor
    logic        rst_s, ce_s;
    logic [28:0] snap;
    bus_t        e;
    snap = '0;
    forever begin
      @(posedge clk);
      rst_s = i_reset;
      ce_s  = i_ce;
      #1;
      if (rst_s) cyc_par = 1'b0;
      else if (ce_s) cyc_par = ~cyc_par;
      if (!rst_s && ce_s) begin
        if (!o_rdy) rdy_low_cnt++;
        if (o_done) begin
          done_cnt++;
          chk("done_rdy", {31'd0, o_rdy}, 32'd1);
          chk("done_queue_empty", q.size(), 32'd0);
        end
        if (o_bus_request) begin
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_bus: got addr %0h rw_n %0b expected no bus cycle", o_address, o_rw_n);
          end else begin
            e = q.pop_front();
            chk("bus_addr", {16'd0, o_address}, {16'd0, e.addr});
            chk("bus_rw_n", {31'd0, o_rw_n}, {31'd0, e.rw_n});
            if (!e.rw_n) chk("bus_wdata", {24'd0, o_data}, {24'd0, e.data});
            chk("bus_parity", {31'd0, cyc_par}, {31'd0, ~e.rw_n});
          end
        end
      end else if (!rst_s) begin
        chk("ce_low_hold", {3'd0, o_address, o_data, o_rw_n, o_bus_request, o_rdy, o_busy, o_done},
            {3'd0, snap});
      end
      snap = {o_address, o_data, o_rw_n, o_bus_request, o_rdy, o_busy, o_done};
    end
  end

  task automatic start(input logic [7:0] page);
    exp_low   = cyc_par ? 514 : 513;
    low_base  = rdy_low_cnt;
    done_base = done_cnt;
    for (int n = 0; n < 256; n++) begin
      q.push_back('{addr: {page, n[7:0]}, rw_n: 1'b1, data: 8'h00});
      q.push_back('{addr: 16'h2004, rw_n: 1'b0, data: mem_byte({page, n[7:0]})});
    end
    i_reg_data = page;
    i_reg_wr   = 1'b1;
    @(negedge clk);
    i_reg_wr   = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !o_busy) break;
    end
    chk({name, "_finished"}, {31'd0, (q.size() == 0 && !o_busy)}, 32'd1);
    chk({name, "_rdy_low_cycles"}, rdy_low_cnt - low_base, exp_low);
    chk({name, "_done_pulses"}, done_cnt - done_base, 32'd1);
  endtask

  task automatic wait_par(input logic p);
    while (cyc_par !== p) @(negedge clk);
  endtask

  initial begin : stim
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    chk("reset_rdy", {31'd0, o_rdy}, 32'd1);
    chk("reset_busy", {31'd0, o_busy}, 32'd0);
    chk("reset_bus_request", {31'd0, o_bus_request}, 32'd0);
    chk("reset_rw_n", {31'd0, o_rw_n}, 32'd1);
    chk("reset_address", {16'd0, o_address}, 32'd0);
    chk("reset_data", {24'd0, o_data}, 32'd0);
    chk("reset_done", {31'd0, o_done}, 32'd0);

    // Odd start: write issued on a parity-1 cycle, HALT lands on a get cycle.
    wait_par(1'b1);
    chk("odd_start_parity", {31'd0, cyc_par}, 32'd1);
    start(8'h02);
    wait_done("odd");

    // Even start: no ALIGN cycle.
    wait_par(1'b0);
    start(8'h02);
    wait_done("even");

    // Data path: writes carry A5, A4, ..., 5A.
    start(8'h03);
    wait_done("data");

    // Page $FF with random ce gating.
    start(8'hFF);
    ce_rand = 1'b1;
    wait_done("page_ff");
    ce_rand = 1'b0;

    // A $4014 write during a transfer is ignored.
    start(8'h02);
    repeat (60) @(negedge clk);
    i_reg_data = 8'h05;
    i_reg_wr   = 1'b1;
    @(negedge clk);
    i_reg_wr   = 1'b0;
    wait_done("busy_wr");
    repeat (20) @(negedge clk);
    chk("busy_wr_idle_after", {31'd0, o_busy}, 32'd0);
    chk("busy_wr_no_second_done", done_cnt - done_base, 32'd1);

    // Reset during the READ of index $40.
    start(8'h02);
    for (int i = 0; i < 2000; i++) begin
      if (o_bus_request && o_rw_n && o_address == 16'h0240) break;
      @(negedge clk);
    end
    chk("rst_saw_read_40", {16'd0, o_address}, 32'h0240);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    q.delete();
    chk("rst_rdy", {31'd0, o_rdy}, 32'd1);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_bus_request", {31'd0, o_bus_request}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_address", {16'd0, o_address}, 32'd0);
    repeat (5) @(negedge clk);
    chk("rst_no_done_pulse", done_cnt - done_base, 32'd0);
    start(8'h01);
    wait_done("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
